inst_sram_resp: RTL and testbench

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

---
 rtl/inst_sram_resp.sv | 153 +++++++++++++++
 tb/tb_inst_sram_resp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_resp.sv
// rtl/inst_sram_resp.sv - instruction SRAM with one-cycle read port and byte-stream program loader
//
// Purpose: single-port instruction memory. The fetch side reads a registered word
// one cycle after the address. A byte-serial loader fills the memory from word 0.
// Optional macro: INST_SRAM_LOAD_CHECKSUM_EN enables the running sum on load_checksum.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   inst_sram_addr    read byte address (bits [1:0] ignored)
//   inst_sram_rdata   registered read data, NOP_WORD when unserviceable
//   load_start        begin a load at word 0 with load_len words
//   load_len          word count, clamped to 2^DEPTH_LOG2
//   load_byte/valid   byte stream in, accepted with load_ready
//   load_ready        high only while loading
//   load_busy         high in LOAD
//   load_done         high in DONE
//   load_checksum     sum of words written since last load_start (0 when disabled)
module inst_sram_resp #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0340_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_rdata,
  input  logic                  load_start,
  input  logic [DEPTH_LOG2:0]   load_len,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [31:0]           load_checksum
);

  localparam int              AW    = DEPTH_LOG2;
  localparam logic [AW:0]     WORDS = (AW+1)'(1) << AW;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [31:0]   r_mem [0:(1<<AW)-1];
  logic [AW:0]   r_ptr;
  logic [AW:0]   r_len;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_acc;
  logic [31:0]   r_rdata;

  logic [29:0]   w_word_offset;
  logic          w_in_range;
  logic [AW-1:0] w_rd_idx;
  logic          w_start;
  logic          w_accept;
  logic          w_word_done;
  logic          w_last_word;
  logic [AW:0]   w_len_clamped;
  logic [31:0]   w_word;
  logic          w_ready;
  logic          w_busy;
  logic          w_done;

  // Word-granular subtraction: BASE_ADDR is a word address, so dropping the low
  // two bits of both operands gives (addr - base) >> 2 modulo 2^30 words, which
  // also wraps addresses below BASE_ADDR to a huge offset (out of range).
  assign w_word_offset = inst_sram_addr[31:2] - BASE_ADDR[31:2];
  assign w_in_range    = (w_word_offset[29:AW] == '0);
  assign w_rd_idx      = w_word_offset[AW-1:0];

  assign w_start       = load_start && (r_state != LOAD);
  assign w_accept      = load_valid && (r_state == LOAD);
  assign w_word_done   = w_accept && (r_byte_cnt == 2'd3);
  assign w_last_word   = ((r_ptr + (AW+1)'(1)) == r_len);
  assign w_len_clamped = (load_len > WORDS) ? WORDS : load_len;
  assign w_word        = {load_byte, r_acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_done = (r_state == DONE);
        if (load_start) w_next_state = (load_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_word_done && w_last_word) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_acc      <= '0;
      r_rdata    <= NOP_WORD;
    end else begin
      r_rdata <= (w_in_range && (r_state != LOAD)) ? r_mem[w_rd_idx] : NOP_WORD;
      if (w_start) begin
        r_ptr      <= '0;
        r_len      <= w_len_clamped;
        r_byte_cnt <= '0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_acc[7:0]   <= load_byte;
          2'd1:    r_acc[15:8]  <= load_byte;
          2'd2:    r_acc[23:16] <= load_byte;
          default: r_ptr        <= r_ptr + (AW+1)'(1);
        endcase
      end
    end
  end

  // Memory has no reset: contents survive rst. Writes only happen in LOAD, and
  // reads are blocked in LOAD, so the two never touch the array on one edge.
  always_ff @(posedge clk) begin
    if (w_word_done) r_mem[r_ptr[AW-1:0]] <= w_word;
  end

`ifdef INST_SRAM_LOAD_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_checksum <= '0;
    else if (w_start)     r_checksum <= '0;
    else if (w_word_done) r_checksum <= r_checksum + w_word;
  end

  assign load_checksum = r_checksum;
`else
  assign load_checksum = '0;
`endif

  assign inst_sram_rdata = r_rdata;
  assign load_ready      = w_ready;
  assign load_busy       = w_busy;
  assign load_done       = w_done;

endmodule

// File: tb/tb_inst_sram_resp.sv
// tb/tb_inst_sram_resp.sv - self-checking bench for inst_sram_resp
module tb_inst_sram_resp;

  localparam int          DL   = 12;
  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam logic [31:0] NOP  = 32'h0340_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst_sram_addr;
  logic [31:0]   inst_sram_rdata;
  logic          load_start;
  logic [DL:0]   load_len;
  logic [7:0]    load_byte;
  logic          load_valid;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;
  logic [31:0]   load_checksum;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  inst_sram_resp dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .load_start      (load_start),
    .load_len        (load_len),
    .load_byte       (load_byte),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_busy       (load_busy),
    .load_done       (load_done),
    .load_checksum   (load_checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_of(input int j);
    return 8'(j ^ (j >> 8));
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return {byte_of(4*i+3), byte_of(4*i+2), byte_of(4*i+1), byte_of(4*i)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    load_byte  = b;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic gap_cycle();
    load_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_load(input logic [DL:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1;
    inst_sram_addr = BASE;
    @(negedge clk);
    @(negedge clk);
    checks++; if (inst_sram_rdata !== NOP) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", inst_sram_rdata, NOP); end
    checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", load_busy); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", load_done); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", load_ready); end
    checks++; if (load_checksum !== 32'h0) begin errors++; $display("FAIL reset_checksum got=%h exp=0", load_checksum); end
    rst = 1'b0;
    @(negedge clk);
    got = inst_sram_rdata;
  endtask

  task automatic test_load_basic();
    logic [7:0]  bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [31:0] addrs [2] = '{BASE, BASE + 32'd4};
    logic [31:0] exps  [2] = '{32'h1234_5678, 32'hDEAD_BEEF};
    logic [31:0] exp_ck;
    start_load(2);
    checks++; if (load_busy !== 1'b1 || load_ready !== 1'b1) begin errors++; $display("FAIL load_enter busy=%b ready=%b exp=1/1", load_busy, load_ready); end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL load_busy_before_last got=%b exp=1", load_busy); end
      end
      send_byte(bytes[i]);
    end
    checks++; if (load_done !== 1'b1 || load_busy !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("FAIL load_done done=%b busy=%b ready=%b exp=1/0/0", load_done, load_busy, load_ready); end
`ifdef INST_SRAM_LOAD_CHECKSUM_EN
    exp_ck = 32'hF0E2_1567;
`else
    exp_ck = 32'h0;
`endif
    checks++; if (load_checksum !== exp_ck) begin errors++; $display("FAIL load_checksum got=%h exp=%h", load_checksum, exp_ck); end
    for (int i = 0; i < 2; i++) begin
      inst_sram_addr = addrs[i];
      exp_q.push_back(exps[i]);
      @(negedge clk);
      begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (inst_sram_rdata !== e) begin errors++; $display("FAIL load_read%0d got=%h exp=%h", i, inst_sram_rdata, e); end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [4] = '{32'h1C00_4000, 32'h1BFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC};
    for (int i = 0; i < 4; i++) begin
      inst_sram_addr = addrs[i];
      exp_q.push_back(NOP);
      @(negedge clk);
      begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (inst_sram_rdata !== e) begin errors++; $display("FAIL oor_%h got=%h exp=%h", addrs[i], inst_sram_rdata, e); end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] addrs [2] = '{BASE, BASE + 32'd4};
    logic [31:0] exps  [2] = '{32'h4433_2211, 32'hDEAD_BEEF};
    start_load(2);
    send_byte(8'h11); gap_cycle();
    send_byte(8'h22); gap_cycle(); gap_cycle();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55); gap_cycle();
    send_byte(8'h66);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (load_busy !== 1'b0 || load_done !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("FAIL midrst_state busy=%b done=%b ready=%b exp=0/0/0", load_busy, load_done, load_ready); end
    checks++; if (inst_sram_rdata !== NOP) begin errors++; $display("FAIL midrst_rdata got=%h exp=%h", inst_sram_rdata, NOP); end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      inst_sram_addr = addrs[i];
      exp_q.push_back(exps[i]);
      @(negedge clk);
      begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (inst_sram_rdata !== e) begin errors++; $display("FAIL midrst_read%0d got=%h exp=%h", i, inst_sram_rdata, e); end
      end
    end
  endtask

  task automatic test_zero_len();
    start_load(0);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", load_done); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL zero_ready%0d got=%b exp=0", i, load_ready); end
      send_byte(8'hA5);
    end
    checks++; if (load_checksum !== 32'h0) begin errors++; $display("FAIL zero_checksum got=%h exp=0", load_checksum); end
    inst_sram_addr = BASE;
    exp_q.push_back(32'h4433_2211);
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (inst_sram_rdata !== e) begin errors++; $display("FAIL zero_nowrite got=%h exp=%h", inst_sram_rdata, e); end
    end
  endtask

  task automatic test_clamp_load();
    logic [31:0] sum = 32'h0;
    logic [31:0] exp_ck;
    int nbytes = 4 * (1 << DL);
    start_load(13'h1FFF);
    for (int j = 0; j < nbytes; j++) begin
      if (j == 100) begin load_start = 1'b1; load_len = 0; end
      if (j == 101) begin
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL start_ignored got=%b exp=1", load_busy); end
      end
      if (j == 200) begin inst_sram_addr = BASE + 32'd8; exp_q.push_back(NOP); end
      if (j == nbytes - 1) begin
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL clamp_busy_before_last got=%b exp=1", load_busy); end
      end
      send_byte(byte_of(j));
      load_start = 1'b0;
      if (j == 200) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (inst_sram_rdata !== e) begin errors++; $display("FAIL read_during_load got=%h exp=%h", inst_sram_rdata, e); end
      end
    end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL clamp_done got=%b exp=1", load_done); end
    for (int i = 0; i < (1 << DL); i++) sum = sum + word_of(i);
`ifdef INST_SRAM_LOAD_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = 32'h0;
`endif
    checks++; if (load_checksum !== exp_ck) begin errors++; $display("FAIL clamp_checksum got=%h exp=%h", load_checksum, exp_ck); end
    inst_sram_addr = BASE + 32'h3FFC;
    exp_q.push_back(word_of((1 << DL) - 1));
    @(negedge clk);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (inst_sram_rdata !== e) begin errors++; $display("FAIL clamp_last_word got=%h exp=%h", inst_sram_rdata, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5] = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'hC, BASE + 32'h9};
    for (int i = 0; i < 5; i++) begin
      inst_sram_addr = addrs[i];
      exp_q.push_back(word_of((i == 4) ? 2 : i));
      @(negedge clk);
      begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (inst_sram_rdata !== e) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, inst_sram_rdata, e); end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    inst_sram_addr = BASE;
    load_start     = 1'b0;
    load_len       = '0;
    load_byte      = '0;
    load_valid     = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_basic();
    test_out_of_range();
    test_reset_mid_load();
    test_zero_len();
    test_clamp_load();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
